// File: rtl/register_file_if.sv
// ---------------------------------------------------------------------------
// register_file_if
//
// Bundles the instruction-driven access signals of the register file.
// There is no valid/ready handshake: every signal is level-sensitive.
// instr, RegWrite and Writedata are sampled on the rising clock edge for the
// write port, while rd1/rd2 follow instr and the register contents
// combinationally.
//
// Signals:
//   RegWrite   write enable for register rd (instr[11:7])
//   instr      instruction word; rs1=[19:15], rs2=[24:20], rd=[11:7]
//   Writedata  data written to register rd
//   rd1        contents of register rs1
//   rd2        contents of register rs2
//
// Modports:
//   master  decode/datapath side driving the instruction and write data
//   slave   the register file itself
// ---------------------------------------------------------------------------
interface register_file_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  RegWrite;
    logic [31:0]           instr;
    logic [DATA_WIDTH-1:0] Writedata;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;

    modport master (
        output RegWrite,
        output instr,
        output Writedata,
        input  rd1,
        input  rd2
    );

    modport slave (
        input  RegWrite,
        input  instr,
        input  Writedata,
        output rd1,
        output rd2
    );
endinterface

// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//
// 32 x 32-bit general-purpose register file for a RISC-V style datapath.
// Two combinational read ports (rs1, rs2) and one synchronous write port
// (rd), all addressed directly from fields of the instruction word.
// Register x0 reads as zero and ignores writes.
//
// Ports:
//   clk    system clock; writes happen on the rising edge
//   rst_n  asynchronous active-low reset; clears every register at once
//   bus    register_file_if.slave
//            RegWrite, instr, Writedata in; rd1, rd2 out
// ---------------------------------------------------------------------------
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    register_file_if.slave  bus
);
    // The address width is fixed by the instruction encoding.
    localparam int ADDR_WIDTH = 5;

    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  write_en;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    assign rs1 = bus.instr[19:15];
    assign rs2 = bus.instr[24:20];
    assign rd  = bus.instr[11:7];

    // Writes aimed at x0 are dropped here so regs[0] keeps its reset value.
    assign write_en = bus.RegWrite && (rd != '0);

    // Opcode/funct bits play no part in register access.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.instr[31:25], bus.instr[14:12], bus.instr[6:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[rd] <= bus.Writedata;
        end
    end

    // No write-through bypass: a read of the register being written shows
    // the old value until the edge has updated the array.  The explicit
    // zero select keeps x0 reading zero regardless of the array contents.
    assign bus.rd1 = (rs1 == '0) ? '0 : regs[rs1];
    assign bus.rd2 = (rs2 == '0) ? '0 : regs[rs2];

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//
// Directed bench for register_file.  A behavioural model (an array of 32
// words updated by the architectural write rule) is checked against both
// read ports on every falling clock edge; directed steps add literal
// expectations at hand-chosen points, including between clock edges.
// ---------------------------------------------------------------------------
module tb_register_file;

    logic clk;
    logic rst_n;

    register_file_if #(.DATA_WIDTH(32)) bus ();

    register_file #(
        .DATA_WIDTH (32),
        .NUM_REGS   (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // -----------------------------------------------------------------------
    // Counters and the checking primitive
    // -----------------------------------------------------------------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model: architectural register contents
    // -----------------------------------------------------------------------
    logic [31:0] model_regs [32] = '{default: 32'h0};

    always @(negedge rst_n) begin
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    end

    always @(posedge clk) begin
        int dst;
        dst = int'(bus.instr[11:7]);
        if (rst_n === 1'b1 && bus.RegWrite === 1'b1 && dst != 0)
            model_regs[dst] = bus.Writedata;
    end

    // Compare process: read ports against the model every falling edge.
    always @(negedge clk) begin
        check("rd1_model", bus.rd1, model_regs[int'(bus.instr[19:15])]);
        check("rd2_model", bus.rd2, model_regs[int'(bus.instr[24:20])]);
    end

    // -----------------------------------------------------------------------
    // Driver tasks (inputs change 1 time unit after the rising edge)
    // -----------------------------------------------------------------------
    task automatic do_write(input logic [31:0] ins, input logic [31:0] data);
        bus.RegWrite  = 1'b1;
        bus.instr     = ins;
        bus.Writedata = data;
        @(posedge clk);
        #1;
        bus.RegWrite  = 1'b0;
    endtask

    task automatic set_instr(input logic [31:0] ins);
        bus.instr = ins;
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        rst_n         = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.instr     = 32'h0;
        bus.Writedata = 32'h0;

        // 1. Reset held two cycles, then read x1/x2.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_instr(32'h0020_8000);
        check("reset_rd1", bus.rd1, 32'h0000_0000);
        check("reset_rd2", bus.rd2, 32'h0000_0000);

        // 2. Write x1, x2 and read back.
        do_write(32'h0000_0080, 32'hFFFF_EEEE);
        do_write(32'h0000_0100, 32'h0000_1111);
        set_instr(32'h0020_8000);
        check("wr_rd1_x1", bus.rd1, 32'hFFFF_EEEE);
        check("wr_rd2_x2", bus.rd2, 32'h0000_1111);

        // 3. x0 is not writable.
        do_write(32'h0000_0000, 32'hDEAD_BEEF);
        set_instr(32'h0000_0000);
        check("x0_rd1", bus.rd1, 32'h0000_0000);
        check("x0_rd2", bus.rd2, 32'h0000_0000);

        // 4. RegWrite low: nothing changes.
        bus.RegWrite  = 1'b0;
        bus.instr     = 32'h0000_0080;
        bus.Writedata = 32'h1234_5678;
        @(posedge clk);
        #1;
        set_instr(32'h0000_8000);
        check("nowr_rd1_x1", bus.rd1, 32'hFFFF_EEEE);
        check("nowr_rd2_x0", bus.rd2, 32'h0000_0000);

        // Field extraction: all non-address bits set, rd=3.
        do_write(32'hFFFF_F1FF, 32'h0BAD_F00D);
        set_instr(32'h0001_8000);
        check("field_rd1_x3", bus.rd1, 32'h0BAD_F00D);

        // x31 through both ports on the same register.
        do_write(32'h0000_0F80, 32'hCAFE_F00D);
        set_instr(32'h01FF_8000);
        check("x31_rd1", bus.rd1, 32'hCAFE_F00D);
        check("x31_rd2", bus.rd2, 32'hCAFE_F00D);

        // 5. Same-register read/write on x5: old value before, new after.
        do_write(32'h0002_8280, 32'h0000_5555);
        bus.RegWrite  = 1'b1;
        bus.instr     = 32'h0002_8280;
        bus.Writedata = 32'hA5A5_A5A5;
        #1;
        check("rw_before_edge", bus.rd1, 32'h0000_5555);
        @(posedge clk);
        #1;
        check("rw_after_edge", bus.rd1, 32'hA5A5_A5A5);
        bus.RegWrite = 1'b0;

        // 6. Asynchronous reset pulse between edges.
        set_instr(32'h0020_8000);
        check("pre_rst_rd1", bus.rd1, 32'hFFFF_EEEE);
        check("pre_rst_rd2", bus.rd2, 32'h0000_1111);
        rst_n = 1'b0;
        #1;
        check("async_rst_rd1", bus.rd1, 32'h0000_0000);
        check("async_rst_rd2", bus.rd2, 32'h0000_0000);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            set_instr({7'h0, 5'(31 - i), 5'(i), 15'h0});
            check("post_rst_rd1", bus.rd1, 32'h0000_0000);
            check("post_rst_rd2", bus.rd2, 32'h0000_0000);
        end

        // Reset dominates a write across a rising edge.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        do_write(32'h0000_0200, 32'h7777_7777);
        set_instr(32'h0022_0000);
        check("rst_dom_rd1_x4", bus.rd1, 32'h0000_0000);
        check("rst_dom_rd2_x2", bus.rd2, 32'h0000_0000);

        // Release mid-cycle: the next rising edge writes.
        #2;
        rst_n = 1'b1;
        do_write(32'h0000_0200, 32'h7777_7777);
        set_instr(32'h0000_0000 | (32'd4 << 15) | (32'd4 << 20));
        check("post_rel_rd1_x4", bus.rd1, 32'h7777_7777);
        check("post_rel_rd2_x4", bus.rd2, 32'h7777_7777);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
32 x 32-bit general-purpose register file for a RISC-V style datapath. Read and write addresses are decoded directly from the instruction word: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7]. There are two combinational read ports and one synchronous write port. Register x0 is hardwired to zero. The block sits between instruction fetch/decode and the ALU operand inputs.

Parameters:
DATA_WIDTH  32  width of each register and of the data ports
NUM_REGS    32  number of registers; the address field is 5 bits and is fixed by the instruction format

Ports:
clk        input   1   system clock; writes occur on the rising edge
rst_n      input   1   asynchronous active-low reset
RegWrite   input   1   write enable for the rd port
instr      input   32  instruction word; the register address fields are extracted from it
Writedata  input   32  data written to register rd
rd1        output  32  contents of register rs1 (instr[19:15])
rd2        output  32  contents of register rs2 (instr[24:20])

Behaviour:
- Address decode:
  - rs1 = instr[19:15], rs2 = instr[24:20], rd = instr[11:7].
  - All other instruction bits are ignored.
- Reset:
  - rst_n low clears all 32 registers to 0x00000000 immediately, without waiting for a clock.
  - rd1 and rd2 therefore read 0 while reset is held and after it.
  - Reset dominates any concurrent write.
  - Reset deasserting mid-operation: the first write takes effect at the first rising clk edge where rst_n is high.
- Write:
  - On a rising clk edge with rst_n=1 and RegWrite=1, reg[rd] <= Writedata.
  - With RegWrite=0, no register changes.
  - Write latency is one edge: the new value is visible on the read ports after that edge.
- x0:
  - Writes with rd=0 are discarded.
  - Reading address 0 always returns 0x00000000.
- Read:
  - Purely combinational: rd1 = reg[rs1], rd2 = reg[rs2].
  - Outputs update in the same delta as any instr change or register update.
  - Both ports may address the same register; each returns the same value.
- Same-cycle read/write of one register:
  - No write-through bypass.
  - Before the edge the read port shows the old value; after the edge it shows the new value.
- Undefined or X on instr is not sanitised; X propagates.

Test Plan:
1. Reset: assert rst_n=0 for two cycles, release, set instr=0x00208000 -> rd1=0x00000000, rd2=0x00000000.
2. Write and read back:
   - RegWrite=1, instr=0x00000080 (rd=1), Writedata=0xFFFFEEEE, one edge.
   - Then instr=0x00000100 (rd=2), Writedata=0x00001111, one edge.
   - Then RegWrite=0, instr=0x00208000 -> rd1=0xFFFFEEEE, rd2=0x00001111.
3. x0 protection: RegWrite=1, instr=0x00000000, Writedata=0xDEADBEEF, edge; then read rs1=rs2=0 -> rd1=rd2=0x00000000.
4. Write disabled: RegWrite=0, instr=0x00000080, Writedata=0x12345678, edge; then instr=0x00008000 (rs1=1) -> rd1 still 0xFFFFEEEE.
5. Same-register read/write: instr with rs1=rd=5, RegWrite=1, Writedata=0xA5A5A5A5.
   - rd1 shows the old value before the edge.
   - rd1 shows 0xA5A5A5A5 immediately after the edge.
6. Async reset mid-cycle: after x1 and x2 are loaded, pulse rst_n low between clock edges -> rd1 and rd2 drop to 0 without a clock edge; x31 and the other registers also read 0 afterwards.
